// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and sizes for the vending transaction controller
package vend_pkg;

    localparam int ITEM_W    = 2;
    localparam int STOCK_W   = 4;
    localparam int NUM_ITEMS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_VEND,
        S_CHANGE
    } vend_state_t;

endpackage

// File: rtl/vend_controller_stock_bank.sv
// rtl/vend_controller_stock_bank.sv - per-item saturating stock counters with reload
module stock_bank
    import vend_pkg::*;
#(
    parameter logic [STOCK_W-1:0] INIT_STOCK = 4'd5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restock,
    input  logic               dec_en,
    input  logic [ITEM_W-1:0]  dec_item,
    input  logic [ITEM_W-1:0]  rd_item,
    output logic [STOCK_W-1:0] rd_level
);

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

    // A reload in the same cycle as a sale wins over the decrement.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (restock) begin
                stock_d[i] = INIT_STOCK;
            end else if (dec_en && (dec_item == ITEM_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (!rst_n) begin
                stock_q[i] <= INIT_STOCK;
            end else begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign rd_level = stock_q[rd_item];

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending transaction controller; VEND_ESCROW_TIMEOUT_EN adds idle auto-refund
module vend_controller
    import vend_pkg::*;
#(
    parameter int                     CREDIT_W   = 8,
    parameter logic [CREDIT_W-1:0]    MAX_CREDIT = 8'd50,
    parameter logic [STOCK_W-1:0]     INIT_STOCK = 4'd5
`ifdef VEND_ESCROW_TIMEOUT_EN
    ,
    parameter int                     TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    output logic                coin_reject,
    input  logic                select_valid,
    input  logic [ITEM_W-1:0]   item_select,
    input  logic                cancel,
    input  logic                restock,
    output logic [ITEM_W-1:0]   item_sel_out,
    output logic [STOCK_W-1:0]  stock_level_out,
    input  logic [CREDIT_W-1:0] price_in,
    output logic                dispense_valid,
    output logic [ITEM_W-1:0]   dispense_item,
    input  logic                dispense_ready,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                sold_out,
    output logic                insufficient
);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ITEM_W-1:0]   item_q, item_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;
    logic                insufficient_q, insufficient_d;
    logic                dec_en;
    logic [STOCK_W-1:0]  stock_level;
    logic [CREDIT_W:0]   coin_sum;

`ifdef VEND_ESCROW_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    stock_bank #(.INIT_STOCK(INIT_STOCK)) u_stock_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .restock  (restock),
        .dec_en   (dec_en),
        .dec_item (item_q),
        .rd_item  (item_q),
        .rd_level (stock_level)
    );

    // Extra carry bit so an overflowing coin is caught instead of wrapping.
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        item_d         = item_q;
        coin_reject_d  = 1'b0;
        sold_out_d     = 1'b0;
        insufficient_d = 1'b0;
        dec_en         = 1'b0;
`ifdef VEND_ESCROW_TIMEOUT_EN
        timer_d        = '0;
`endif
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (cancel && (credit_q != '0)) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_valid;
                end else begin
                    if (coin_valid) begin
                        if (coin_sum <= {1'b0, MAX_CREDIT}) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    if (select_valid) begin
                        item_d  = item_select;
                        state_d = S_CHECK;
                    end else begin
                        state_d = (credit_d != '0) ? S_COLLECT : S_IDLE;
                    end
                end
`ifdef VEND_ESCROW_TIMEOUT_EN
                if ((state_q == S_COLLECT) && !coin_valid && !select_valid && !cancel) begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_CHANGE;
                        timer_d = '0;
                    end
                end
`endif
            end
            S_CHECK: begin
                coin_reject_d = coin_valid;
                if (stock_level == '0) begin
                    sold_out_d = 1'b1;
                    state_d    = (credit_q != '0) ? S_COLLECT : S_IDLE;
                end else if (credit_q < price_in) begin
                    insufficient_d = 1'b1;
                    state_d        = (credit_q != '0) ? S_COLLECT : S_IDLE;
                end else begin
                    credit_d = credit_q - price_in;
                    dec_en   = 1'b1;
                    state_d  = S_VEND;
                end
            end
            S_VEND: begin
                coin_reject_d = coin_valid;
                if (dispense_ready) begin
                    state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ready) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            item_q         <= '0;
            coin_reject_q  <= 1'b0;
            sold_out_q     <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            item_q         <= item_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_q     <= sold_out_d;
            insufficient_q <= insufficient_d;
        end
    end

`ifdef VEND_ESCROW_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign item_sel_out    = item_q;
    assign stock_level_out = stock_level;
    assign dispense_valid  = (state_q == S_VEND);
    assign dispense_item   = item_q;
    assign change_valid    = (state_q == S_CHANGE);
    assign change_amount   = credit_q;
    assign credit          = credit_q;
    assign coin_reject     = coin_reject_q;
    assign sold_out        = sold_out_q;
    assign insufficient    = insufficient_q;

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction controller that drives the item price lookup and consumes its result.
- Sends `item_sel_out` and `stock_level_out` to the lookup; receives `price_in` back.
- Collects coins into a credit register, checks stock and credit, and decrements per-item inventory on a sale.
- Hands the item to the dispenser and returns change through valid/ready handshakes.

Parameters:
- CREDIT_W, 8, width of credit, coin, price and change datapaths.
- MAX_CREDIT, 8'd50, credit ceiling; a coin that would push credit above it is rejected.
- INIT_STOCK, 4'd5, per-item stock loaded at reset and on restock.
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- coin_valid  in  1  one-cycle coin event.
- coin_value  in  CREDIT_W  coin denomination.
- coin_reject  out  1  one-cycle pulse: coin not credited.
- select_valid  in  1  one-cycle item request.
- item_select  in  2  requested item 0..3.
- cancel  in  1  refund request.
- restock  in  1  reload all stock to INIT_STOCK.
- item_sel_out  out  2  latched item, to the price lookup.
- stock_level_out  out  4  stock of the latched item, to the price lookup.
- price_in  in  CREDIT_W  price from the lookup (combinational).
- dispense_valid  out  1  item ready to dispense.
- dispense_item  out  2  item being dispensed.
- dispense_ready  in  1  dispenser accepts.
- change_valid  out  1  change offered.
- change_amount  out  CREDIT_W  change value.
- change_ready  in  1  change accepted.
- credit  out  CREDIT_W  current credit.
- sold_out  out  1  one-cycle pulse.
- insufficient  out  1  one-cycle pulse.

Behaviour:
- Reset (synchronous, rst_n=0 at an edge):
  - state=IDLE; credit=0; latched item=0.
  - All stock=INIT_STOCK.
  - All valid and pulse outputs are 0.
  - Reset mid-transaction abandons it: no change is returned, and stock returns to INIT_STOCK.
- States: IDLE (credit==0), COLLECT (credit>0), CHECK, VEND, CHANGE.
- IDLE/COLLECT:
  - Coin accepted: credit+=coin_value when credit+coin_value<=MAX_CREDIT, computed at CREDIT_W+1 bits with no wrap.
  - Otherwise pulse coin_reject for 1 cycle; credit unchanged.
  - select_valid latches item_select → CHECK. A coin in the same cycle is credited first.
  - cancel with credit>0 → CHANGE. cancel with credit==0 is ignored.
  - cancel has priority over select and coin in the same cycle; that coin gets coin_reject.
- item_sel_out and stock_level_out always reflect the latched item. price_in is sampled in CHECK, one cycle after latching.
- CHECK (exactly 1 cycle), first match wins:
  - stock==0: pulse sold_out → COLLECT, or IDLE if credit==0.
  - credit<price_in: pulse insufficient → same return rule.
  - Otherwise: credit-=price_in; stock[item]-=1; → VEND.
- VEND:
  - dispense_valid=1, dispense_item=latched item; held stable until dispense_ready.
  - On handshake: → CHANGE if credit>0, else IDLE.
- CHANGE:
  - change_valid=1, change_amount=credit; held stable until change_ready.
  - On handshake: credit=0 → IDLE.
- Coins arriving in CHECK/VEND/CHANGE get coin_reject and are not credited. select and cancel are ignored outside IDLE/COLLECT.
- Stock never underflows; it saturates at 0.
- restock:
  - Applies in any state. Takes effect the next cycle.
  - A same-cycle CHECK decrement is overridden by the reload.
- Latency: select→dispense_valid = 2 cycles. dispense handshake→change_valid = 1 cycle.
- The credit output is registered.

Optional Feature:
- Macro: VEND_ESCROW_TIMEOUT_EN.
- Defined:
  - A counter runs in COLLECT and clears on any coin, select or cancel.
  - At TIMEOUT_CYCLES it forces → CHANGE (auto-refund of full credit).
  - The counter clears on entry to any other state.
- Undefined: no counter logic; credit is held indefinitely.

Decomposition:
- vend_pkg:
  - state enum (IDLE, COLLECT, CHECK, VEND, CHANGE).
  - ITEM_W=2, STOCK_W=4, NUM_ITEMS=4.
- Sub-module stock_bank:
  - Four 4-bit saturating counters with reset/restock load.
  - Decrement strobe plus item index; read port for the selected item.

Test Plan:
- Defaults, item1 stock 5 (price 4): coin 5, select 1 → after CHECK dispense_valid, dispense_item=1; after dispense_ready change_valid, change_amount=1; then credit=0, IDLE, stock1=4.
- Coin 2, select item2 (price 6) → insufficient pulse, credit stays 2, state COLLECT, stock2 unchanged.
- Buy item0 five times with exact credit (stock drops to 2, then price 4) → sixth select gives sold_out pulse, no dispense; restock → stock0=5.
- Coins 5+2, cancel → change_amount=7; hold change_ready=0 for 3 cycles and check value stays stable; then credit=0.
- Credit 48, coin 5 → coin_reject, credit 48. Coin 2 → credit 50. Coin during VEND → coin_reject.
- rst_n=0 during VEND → next cycle dispense_valid=0, credit=0, stock=INIT_STOCK. With VEND_ESCROW_TIMEOUT_EN and TIMEOUT_CYCLES=10: coin 3 then idle → change_valid after 10 cycles.
